// File: rtl/usb_pkg.sv
// usb_pkg: shared USB datapath types and sizes
package usb_pkg;
    localparam int TX_FIFO_DEPTH = 64;
    typedef logic [7:0] byte_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, occupancy, full/empty and error-pulse control for a byte FIFO
// Ports: clk, n_rst (async active-low); w_enable/r_enable/flush requests;
// push (accepted write strobe for the storage array), wr_ptr/rd_ptr (storage indices);
// empty/full/occupancy status; overrun/underrun one-cycle error pulses.
module fifo_ptr_ctrl #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          w_enable,
    input  logic          r_enable,
    input  logic          flush,
    output logic          push,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   occupancy,
    output logic          overrun,
    output logic          underrun
);
    logic pop;
    assign empty = occupancy == '0;
    assign full  = occupancy == (AW+1)'(DEPTH);
    assign push  = w_enable & ~full & ~flush;
    assign pop   = r_enable & ~empty & ~flush;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overrun  <= w_enable & full & ~flush;
            underrun <= r_enable & empty & ~flush;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push & ~pop) occupancy <= occupancy + 1'b1;
                else if (pop & ~push) occupancy <= occupancy - 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_fifo.sv
// tx_fifo: transmit-side first-word-fall-through byte FIFO for the USB endpoint
// Ports: clk, n_rst (async active-low); w_enable/w_data push side (AHB slave);
// r_enable pop side and r_data head byte (TX encoder), 8'h00 while empty;
// flush clears contents; empty/full/occupancy status; overrun/underrun error pulses.
module tx_fifo
    import usb_pkg::*;
#(
    parameter int DEPTH = TX_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        w_enable,
    input  logic [7:0]  w_data,
    input  logic        r_enable,
    input  logic        flush,
    output logic [7:0]  r_data,
    output logic        empty,
    output logic        full,
    output logic [AW:0] occupancy,
    output logic        overrun,
    output logic        underrun
);
    byte_t         mem [DEPTH];
    logic          push;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .w_enable  (w_enable),
        .r_enable  (r_enable),
        .flush     (flush),
        .push      (push),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .empty     (empty),
        .full      (full),
        .occupancy (occupancy),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    // Storage is not reset; the empty gate on r_data hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data;
    end

    assign r_data = empty ? 8'h00 : mem[rd_ptr];
endmodule

// File: tb/tb_tx_fifo.sv
// tb_tx_fifo: randomized and directed checks of tx_fifo against a queue model
module tb_tx_fifo;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       w_enable = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       r_enable = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [6:0] occupancy;
    logic       overrun;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic exp_ovr = 1'b0;
    logic exp_und = 1'b0;

    tx_fifo dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .w_enable  (w_enable),
        .w_data    (w_data),
        .r_enable  (r_enable),
        .flush     (flush),
        .r_data    (r_data),
        .empty     (empty),
        .full      (full),
        .occupancy (occupancy),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == 64));
        check("r_data", 32'(r_data), q.size() > 0 ? 32'(q[0]) : 32'h0);
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("underrun", 32'(underrun), 32'(exp_und));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        bit was_full;
        bit was_empty;
        w_enable = w;
        w_data   = d;
        r_enable = r;
        flush    = f;
        @(posedge clk);
        was_full  = q.size() == 64;
        was_empty = q.size() == 0;
        if (f) begin
            q.delete();
            exp_ovr = 1'b0;
            exp_und = 1'b0;
        end else begin
            exp_ovr = w && was_full;
            exp_und = r && was_empty;
            if (r && !was_empty) void'(q.pop_front());
            if (w && !was_full) q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        int pw;
        int pr;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        n_rst = 1'b1;
        step(1, 8'hA5, 0, 0);
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        for (int i = 0; i < 64; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hFF, 0, 0);
        step(0, 8'h00, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 64; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'hEE, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h77, 1, 0);
        step(0, 8'h00, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 200; i++) step(1, 8'($urandom), 1, 0);
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'h99, 1, 1);
        step(1, 8'h11, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            pw = ((i / 300) % 2 == 0) ? 75 : 25;
            pr = 100 - pw;
            step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr, ($urandom % 64) == 0);
        end
        for (int i = 0; i < 15; i++) step(1, 8'($urandom), 0, 0);
        w_enable = 1'b0;
        r_enable = 1'b0;
        flush    = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        q.delete();
        exp_ovr = 1'b0;
        exp_und = 1'b0;
        check_all();
        @(negedge clk);
        n_rst = 1'b1;
        step(1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
